// File: rtl/sync_fifo_flags.sv
// Single-clock circular-buffer FIFO with occupancy count, watermark flags, error pulses and flush.
// Latency: a read accepted at edge N presents data_out with rd_valid=1 after edge N; there is no write-to-read bypass.
// Backpressure: a write is refused while full (overflow pulses) and a read while empty (underflow pulses); state holds.
//
// Ports:
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   w_en, data_in            write request and data
//   rd_en                    read request
//   flush                    synchronous discard of all contents (data_out holds)
//   data_out, rd_valid       registered read data and its strobe
//   full, empty              count == DEPTH / count == 0
//   almost_full/almost_empty count >= AFULL_THRESH / count <= AEMPTY_THRESH
//   count                    occupancy 0..DEPTH
//   overflow, underflow      one-cycle pulses for rejected write / read requests
module sync_fifo_flags #(
    parameter int DEPTH         = 8,
    parameter int WIDTH         = 8,
    parameter int AFULL_THRESH  = 6,
    parameter int AEMPTY_THRESH = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     w_en,
    input  logic [WIDTH-1:0]         data_in,
    input  logic                     rd_en,
    input  logic                     flush,
    output logic [WIDTH-1:0]         data_out,
    output logic                     rd_valid,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // Thresholds sized to the count register so the flag compares are width-matched.
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_THRESH);
    localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_THRESH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             wr_acc;
    logic             rd_acc;

    // Flags are purely a function of the count register.
    assign full         = (count == DEPTH_C);
    assign empty        = (count == '0);
    assign almost_full  = (count >= AFULL_C);
    assign almost_empty = (count <= AEMPTY_C);

    assign wr_acc = w_en & ~full;
    assign rd_acc = rd_en & ~empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            data_out  <= '0;
            rd_valid  <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (flush) begin
            // data_out deliberately holds so the last delivered word stays observable.
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            rd_valid  <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_acc) begin
                wptr <= wptr + AW'(1);
            end
            if (rd_acc) begin
                rptr     <= rptr + AW'(1);
                data_out <= mem[rptr];
            end
            rd_valid  <= rd_acc;
            overflow  <= w_en & full;
            underflow <= rd_en & empty;
            count     <= count + CW'(wr_acc) - CW'(rd_acc);
        end
    end

    // Storage has no reset; reset and flush only block the write.
    always_ff @(posedge clk) begin
        if (wr_acc && !rst && !flush) begin
            mem[wptr] <= data_in;
        end
    end

endmodule

// File: tb/tb_sync_fifo_flags.sv
module tb_sync_fifo_flags;

    logic       clk;
    logic       rst;
    logic       w_en;
    logic [7:0] data_in;
    logic       rd_en;
    logic       flush;
    logic [7:0] data_out;
    logic       rd_valid;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic [3:0] count;
    logic       overflow;
    logic       underflow;

    sync_fifo_flags #(
        .DEPTH(8), .WIDTH(8), .AFULL_THRESH(6), .AEMPTY_THRESH(1)
    ) dut (
        .clk(clk), .rst(rst), .w_en(w_en), .data_in(data_in), .rd_en(rd_en),
        .flush(flush), .data_out(data_out), .rd_valid(rd_valid), .full(full),
        .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
        .count(count), .overflow(overflow), .underflow(underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: FIFO contents, expected registered outputs and a
    // scoreboard of read data due on the next rd_valid.
    int mq[$];
    int exp_q[$];
    int exp_dout;
    int exp_rv;
    int exp_ovf;
    int exp_unf;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    // One clock of stimulus, model update and full output comparison.
    task automatic step(input logic r_s, input logic w, input logic [7:0] d,
                        input logic r, input logic f);
        int sz;
        @(negedge clk);
        rst = r_s; w_en = w; data_in = d; rd_en = r; flush = f;
        sz = mq.size();
        if (r_s) begin
            mq.delete(); exp_q.delete();
            exp_dout = 0; exp_rv = 0; exp_ovf = 0; exp_unf = 0;
        end else if (f) begin
            mq.delete(); exp_q.delete();
            exp_rv = 0; exp_ovf = 0; exp_unf = 0;
        end else begin
            exp_ovf = (w && sz == 8) ? 1 : 0;
            exp_unf = (r && sz == 0) ? 1 : 0;
            exp_rv  = 0;
            if (r && sz != 0) begin
                exp_dout = mq.pop_front();
                exp_q.push_back(exp_dout);
                exp_rv = 1;
            end
            if (w && sz != 8) mq.push_back(int'(d));
        end
        @(posedge clk);
        #1;
        rst = 1'b0; w_en = 1'b0; rd_en = 1'b0; flush = 1'b0;
        sz = mq.size();
        chk("count",        int'(count),        sz);
        chk("full",         int'(full),         (sz == 8) ? 1 : 0);
        chk("empty",        int'(empty),        (sz == 0) ? 1 : 0);
        chk("almost_full",  int'(almost_full),  (sz >= 6) ? 1 : 0);
        chk("almost_empty", int'(almost_empty), (sz <= 1) ? 1 : 0);
        chk("overflow",     int'(overflow),     exp_ovf);
        chk("underflow",    int'(underflow),    exp_unf);
        chk("rd_valid",     int'(rd_valid),     exp_rv);
        if (rd_valid) begin
            chk("sb_pending", (exp_q.size() > 0) ? 1 : 0, 1);
            if (exp_q.size() > 0) chk("rd_data", int'(data_out), exp_q.pop_front());
        end else begin
            chk("data_hold", int'(data_out), exp_dout);
        end
    endtask

    initial begin
        rst = 1'b1; w_en = 1'b0; data_in = 8'h00; rd_en = 1'b0; flush = 1'b0;
        exp_dout = 0; exp_rv = 0; exp_ovf = 0; exp_unf = 0;

        // 1: reset, fill with 0x01..0x08, then overflow
        step(1, 0, 8'h00, 0, 0);
        chk("rst_empty", int'(empty), 1);
        chk("rst_aempty", int'(almost_empty), 1);
        for (int i = 1; i <= 8; i++) begin
            step(0, 1, 8'(i), 0, 0);
            if (i == 1) chk("t1_aempty_w1", int'(almost_empty), 1);
            if (i == 2) chk("t1_aempty_w2", int'(almost_empty), 0);
            if (i == 5) chk("t1_afull_w5", int'(almost_full), 0);
            if (i == 6) chk("t1_afull_w6", int'(almost_full), 1);
        end
        chk("t1_full", int'(full), 1);
        chk("t1_count8", int'(count), 8);
        step(0, 1, 8'h09, 0, 0);
        chk("t1_ovf", int'(overflow), 1);
        chk("t1_count_stay", int'(count), 8);
        step(0, 0, 8'h00, 0, 0);
        chk("t1_ovf_pulse", int'(overflow), 0);

        // 2: drain with 9 reads
        for (int i = 1; i <= 9; i++) begin
            step(0, 0, 8'h00, 1, 0);
            if (i <= 8) chk("t2_data", int'(data_out), i);
        end
        chk("t2_unf", int'(underflow), 1);
        chk("t2_rv", int'(rd_valid), 0);
        chk("t2_hold", int'(data_out), 8'h08);

        // 3: steady state at count=4 with wrap
        for (int i = 0; i < 4; i++) step(0, 1, 8'(8'h20 + i), 0, 0);
        for (int i = 0; i < 12; i++) begin
            step(0, 1, 8'(8'h10 + i), 1, 0);
            chk("t3_count4", int'(count), 4);
            if (i < 4) chk("t3_data_old", int'(data_out), 8'h20 + i);
            else       chk("t3_data_new", int'(data_out), 8'h10 + i - 4);
        end

        // 4: simultaneous at full, then at empty
        for (int i = 0; i < 4; i++) step(0, 1, 8'(8'h30 + i), 0, 0);
        chk("t4_full", int'(full), 1);
        step(0, 1, 8'h40, 1, 0);
        chk("t4_ovf", int'(overflow), 1);
        chk("t4_count7", int'(count), 7);
        for (int i = 0; i < 7; i++) step(0, 0, 8'h00, 1, 0);
        chk("t4_empty", int'(empty), 1);
        step(0, 1, 8'h41, 1, 0);
        chk("t4_unf", int'(underflow), 1);
        chk("t4_count1", int'(count), 1);
        step(0, 0, 8'h00, 1, 0);
        chk("t4_bypass_none", int'(data_out), 8'h41);

        // 5: flush at count=5
        for (int i = 0; i < 5; i++) step(0, 1, 8'(8'h50 + i), 0, 0);
        step(0, 1, 8'h5F, 0, 1);
        chk("t5_count0", int'(count), 0);
        chk("t5_empty", int'(empty), 1);
        chk("t5_hold", int'(data_out), 8'h41);
        step(0, 1, 8'hAA, 0, 0);
        step(0, 0, 8'h00, 1, 0);
        chk("t5_aa", int'(data_out), 8'hAA);

        // 6: reset mid-operation with a read in flight
        for (int i = 0; i < 4; i++) step(0, 1, 8'(8'h60 + i), 0, 0);
        step(0, 0, 8'h00, 1, 0);
        chk("t6_count3", int'(count), 3);
        step(1, 1, 8'h77, 1, 1);
        chk("t6_count", int'(count), 0);
        chk("t6_dout", int'(data_out), 0);
        chk("t6_rv", int'(rd_valid), 0);
        step(0, 1, 8'h88, 0, 0);
        step(0, 0, 8'h00, 1, 0);
        chk("t6_after", int'(data_out), 8'h88);

        // Random traffic against the model
        for (int i = 0; i < 200; i++) begin
            step(0, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 31) == 0) ? 1'b1 : 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
